// File: rtl/pipe_pkg.sv
// Shared widths, register-zero constant and the ID/EX bundle used by the
// operand fetch stage and its bypass units.
package pipe_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int CTRLW = 8;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_read;
        logic [XLEN-1:0]  rs_val;
        logic [XLEN-1:0]  rt_val;
        logic [XLEN-1:0]  imm;
        logic [AW-1:0]    rd;
        logic [CTRLW-1:0] ctrl;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundle of ID-side, bypass, register-file and ID/EX signals around the
// operand fetch stage. The slave modport is the stage itself.
interface ofs_if;
    import pipe_pkg::*;

    logic             id_valid;
    logic [AW-1:0]    id_rs;
    logic [AW-1:0]    id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [AW-1:0]    id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic [XLEN-1:0]  id_imm;
    logic [CTRLW-1:0] id_ctrl;
    logic [AW-1:0]    RA;
    logic [AW-1:0]    RB;
    logic [XLEN-1:0]  BusA;
    logic [XLEN-1:0]  BusB;
    logic             exm_reg_write;
    logic             exm_mem_read;
    logic [AW-1:0]    exm_rd;
    logic [XLEN-1:0]  exm_result;
    logic             wb_reg_write;
    logic [AW-1:0]    wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             stall_out;
    logic             ex_valid;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [XLEN-1:0]  ex_rs_val;
    logic [XLEN-1:0]  ex_rt_val;
    logic [XLEN-1:0]  ex_imm;
    logic [AW-1:0]    ex_rd;
    logic [CTRLW-1:0] ex_ctrl;
    logic [31:0]      stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, id_imm, id_ctrl, BusA, BusB,
               exm_reg_write, exm_mem_read, exm_rd, exm_result,
               wb_reg_write, wb_rd, wb_data, flush,
        input  RA, RB, stall_out, ex_valid, ex_reg_write, ex_mem_read,
               ex_rs_val, ex_rt_val, ex_imm, ex_rd, ex_ctrl, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, id_imm, id_ctrl, BusA, BusB,
               exm_reg_write, exm_mem_read, exm_rd, exm_result,
               wb_reg_write, wb_rd, wb_data, flush,
        output RA, RB, stall_out, ex_valid, ex_reg_write, ex_mem_read,
               ex_rs_val, ex_rt_val, ex_imm, ex_rd, ex_ctrl, stall_count
    );

endinterface

// File: rtl/operand_bypass.sv
// One source operand: register-zero check, EX/MEM then MEM/WB forwarding,
// and detection of hazards that forwarding cannot cover.
module operand_bypass
    import pipe_pkg::*;
(
    input  logic            id_valid_i,
    input  logic            uses_i,
    input  logic [AW-1:0]   src_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            exm_reg_write_i,
    input  logic            exm_mem_read_i,
    input  logic [AW-1:0]   exm_rd_i,
    input  logic [XLEN-1:0] exm_result_i,
    input  logic            wb_reg_write_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            ex_valid_i,
    input  logic            ex_reg_write_i,
    input  logic [AW-1:0]   ex_rd_i,
    output logic [XLEN-1:0] operand_o,
    output logic            hazard_o
);

    logic exm_fwd_s;
    logic wb_fwd_s;
    logic dist1_s;
    logic load2_s;

    assign exm_fwd_s = exm_reg_write_i & ~exm_mem_read_i & (exm_rd_i == src_i);
    assign wb_fwd_s  = wb_reg_write_i & (wb_rd_i == src_i);
    assign dist1_s   = ex_valid_i & ex_reg_write_i & (ex_rd_i == src_i);
    assign load2_s   = exm_reg_write_i & exm_mem_read_i & (exm_rd_i == src_i);

    // Forward priority; WB is needed because the register file writes on the edge.
    always_comb begin
        operand_o = rf_data_i;
        if (src_i == REG_ZERO) begin
            operand_o = {XLEN{1'b0}};
        end else if (exm_fwd_s) begin
            operand_o = exm_result_i;
        end else if (wb_fwd_s) begin
            operand_o = wb_data_i;
        end else begin
            operand_o = rf_data_i;
        end
    end

    // Producer still in EX, or a load whose data only appears at MEM/WB.
    always_comb begin
        hazard_o = 1'b0;
        if (id_valid_i && uses_i && (src_i != REG_ZERO)) begin
            hazard_o = dist1_s | load2_s;
        end else begin
            hazard_o = 1'b0;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch with bypassing, stall generation, ID/EX pipeline register
// and a saturating stall-cycle counter.
module operand_fetch_stage
    import pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    ofs_if.slave  bus
);

    idex_t           idex_q;
    idex_t           idex_d;
    logic [31:0]     stall_count_q;
    logic [31:0]     stall_count_d;
    logic [XLEN-1:0] rs_val_s;
    logic [XLEN-1:0] rt_val_s;
    logic            rs_haz_s;
    logic            rt_haz_s;
    logic            stall_s;

    assign bus.RA = bus.id_rs;
    assign bus.RB = bus.id_rt;

    operand_bypass u_bypass_rs (
        .id_valid_i      (bus.id_valid),
        .uses_i          (bus.id_uses_rs),
        .src_i           (bus.id_rs),
        .rf_data_i       (bus.BusA),
        .exm_reg_write_i (bus.exm_reg_write),
        .exm_mem_read_i  (bus.exm_mem_read),
        .exm_rd_i        (bus.exm_rd),
        .exm_result_i    (bus.exm_result),
        .wb_reg_write_i  (bus.wb_reg_write),
        .wb_rd_i         (bus.wb_rd),
        .wb_data_i       (bus.wb_data),
        .ex_valid_i      (idex_q.valid),
        .ex_reg_write_i  (idex_q.reg_write),
        .ex_rd_i         (idex_q.rd),
        .operand_o       (rs_val_s),
        .hazard_o        (rs_haz_s)
    );

    operand_bypass u_bypass_rt (
        .id_valid_i      (bus.id_valid),
        .uses_i          (bus.id_uses_rt),
        .src_i           (bus.id_rt),
        .rf_data_i       (bus.BusB),
        .exm_reg_write_i (bus.exm_reg_write),
        .exm_mem_read_i  (bus.exm_mem_read),
        .exm_rd_i        (bus.exm_rd),
        .exm_result_i    (bus.exm_result),
        .wb_reg_write_i  (bus.wb_reg_write),
        .wb_rd_i         (bus.wb_rd),
        .wb_data_i       (bus.wb_data),
        .ex_valid_i      (idex_q.valid),
        .ex_reg_write_i  (idex_q.reg_write),
        .ex_rd_i         (idex_q.rd),
        .operand_o       (rt_val_s),
        .hazard_o        (rt_haz_s)
    );

    // A flush or reset cancels the instruction, so it must also cancel the stall.
    assign stall_s       = (rs_haz_s | rt_haz_s) & ~bus.flush & rst_n;
    assign bus.stall_out = stall_s;

    // Next ID/EX contents: a bubble unless a valid instruction advances.
    always_comb begin
        idex_d = IDEX_BUBBLE;
        if (!rst_n || bus.flush || stall_s || !bus.id_valid) begin
            idex_d = IDEX_BUBBLE;
        end else begin
            idex_d.valid     = 1'b1;
            idex_d.reg_write = bus.id_reg_write;
            idex_d.mem_read  = bus.id_mem_read;
            idex_d.rs_val    = rs_val_s;
            idex_d.rt_val    = rt_val_s;
            idex_d.imm       = bus.id_imm;
            idex_d.rd        = bus.id_rd;
            idex_d.ctrl      = bus.id_ctrl;
        end
    end

    // Saturating stall counter next value.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_s && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // ID/EX register and stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q        <= IDEX_BUBBLE;
            stall_count_q <= 32'd0;
        end else begin
            idex_q        <= idex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.ex_valid     = idex_q.valid;
    assign bus.ex_reg_write = idex_q.reg_write;
    assign bus.ex_mem_read  = idex_q.mem_read;
    assign bus.ex_rs_val    = idex_q.rs_val;
    assign bus.ex_rt_val    = idex_q.rt_val;
    assign bus.ex_imm       = idex_q.imm;
    assign bus.ex_rd        = idex_q.rd;
    assign bus.ex_ctrl      = idex_q.ctrl;
    assign bus.stall_count  = stall_count_q;

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-side operand fetch and ID/EX pipeline register for the 5-stage pipeline. Drives the register-file read addresses and takes the combinational read data. Bypasses results from EX/MEM and MEM/WB, detects data hazards that need stalling, and registers the fetched operands and control into ID/EX. The MEM/WB inputs are the same signals that drive the register-file write port.

## Interface
- XLEN, 32, datapath width
- AW, 5, register address width
- CTRLW, 8, opaque control bundle passed to EX
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- id_valid  in  1  valid instruction in ID
- id_rs, id_rt  in  AW  source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_rd  in  AW  destination register
- id_reg_write, id_mem_read  in  1  writes rd / is load
- id_imm  in  XLEN  decoded immediate
- id_ctrl  in  CTRLW  control bundle
- RA, RB  out  AW  register-file read addresses; combinationally equal id_rs, id_rt
- BusA, BusB  in  XLEN  register-file read data
- exm_reg_write, exm_mem_read  in  1  EX/MEM writes rd / is load
- exm_rd  in  AW; exm_result  in  XLEN  EX/MEM ALU result
- wb_reg_write  in  1; wb_rd  in  AW; wb_data  in  XLEN  MEM/WB write port
- flush  in  1  squash the ID instruction (branch redirect)
- stall_out  out  1  hold PC and IF/ID this cycle
- ex_valid, ex_reg_write, ex_mem_read  out  1  ID/EX flags
- ex_rs_val, ex_rt_val, ex_imm  out  XLEN  ID/EX operands
- ex_rd  out  AW; ex_ctrl  out  CTRLW
- stall_count  out  32  count of stall cycles, saturating

## Operation
- Operand select, per source, in priority order:
  - Register 0 returns 0.
  - Else, if exm_reg_write & ~exm_mem_read & exm_rd==src, return exm_result.
  - Else, if wb_reg_write & wb_rd==src, return wb_data. This case is required because the register file writes on the edge, so a same-cycle read returns the old value.
  - Else return BusA/BusB.
- Hazards are evaluated only when id_valid is 1 and the source is used and non-zero (id_uses_x & src!=0):
  - Distance 1: ex_valid & ex_reg_write & ex_rd==src. Stall, because the producer is still in EX.
  - Distance-2 load: exm_reg_write & exm_mem_read & exm_rd==src. Stall, because the load data is not ready until MEM/WB.
- stall_out = (either hazard on either source) & ~flush & rst_n.
- ID/EX update on each edge:
  - If rst_n=0, flush, stall_out, or ~id_valid: load a bubble. A bubble sets all ex_* outputs to 0.
  - Otherwise: load the selected operands, id_imm, id_rd, id_reg_write, id_mem_read, id_ctrl, and set ex_valid=1.
- stall_count increments on each edge where stall_out=1. It holds at 0xFFFFFFFF.

## Timing
- Reset: all ex_* outputs 0 and stall_count 0 after the first edge with rst_n=0. stall_out is 0 while rst_n=0.
- Latency: one cycle from ID inputs to ex_* outputs.
- stall_out is combinational from the ID inputs and the registered ex_* state, in the same cycle.
- Stall lengths:
  - ALU-to-use at distance 1: one stall cycle, then the value forwards from EX/MEM.
  - Load-to-use at distance 1: two stall cycles, then the value forwards from WB.
- flush together with a hazard: flush wins. A bubble is loaded, stall_out=0, and stall_count does not increment.
- rs and rt both hazarded: still a single stall_out, and one count per cycle.
- Reset mid-stall: the bubble is loaded and stall_out drops in the same cycle.

## Structure
- Shared package pipe_pkg holds XLEN, AW, CTRLW, REG_ZERO, and the bubble constant for the ID/EX bundle.
- Sub-module operand_bypass handles one source: the zero check, the forward priority mux, and the hazard compare. It is instantiated twice, for rs and rt. The top level keeps the ID/EX register, the stall OR, and the counter.

## Test plan
- Forward priority:
  - Stimulus: id_rs=3, exm_rd=3 with exm_reg_write=1, exm_result=0xAAAA0000, wb_rd=3 with wb_data=0x5555, BusA=0x1.
  - Required: ex_rs_val=0xAAAA0000 next cycle.
  - Then drop exm_reg_write. Required: 0x5555.
  - Then drop wb_reg_write. Required: 0x1.
- Load-use:
  - Stimulus: a load to r5, followed by an instruction using r5.
  - Required: stall_out=1 for exactly 2 cycles; two bubbles with ex_valid=0; stall_count=2; the consumer gets the WB data.
- ALU dependency at distance 1:
  - Stimulus: an ALU write to r7, then an instruction using r7 as rt.
  - Required: one stall cycle; ex_rt_val=exm_result.
- Register 0:
  - Stimulus: id_rs=0 with a pending writer to r0 and BusA=0xDEADBEEF.
  - Required: no stall, ex_rs_val=0.
- Flush over stall:
  - Stimulus: a load-use hazard with flush=1 in the same cycle.
  - Required: stall_out=0, a bubble in ID/EX, stall_count unchanged.
- Reset:
  - Stimulus: rst_n=0 during a stall.
  - Required: the next cycle has every ex_* output and stall_count at 0, and stall_out=0.
